// File: rtl/bpsk_correlator_rx_if.sv
// Sample-side and codeword-side signals of the BPSK correlating receiver.
// en marks a valid sample (the receiver has no ready and accepts every en cycle);
// q_valid is a one-cycle pulse with no backpressure, q holds until the next pulse.
interface bpsk_correlator_rx_if #(
   parameter int SAMPLE_WIDTH = 12,
   parameter int CNT_WIDTH    = 8,
   parameter int DATA_WIDTH   = 12
);
   logic                           en;
   logic signed [SAMPLE_WIDTH-1:0] signal_in;
   logic signed [SAMPLE_WIDTH-1:0] sin_in;
   logic [CNT_WIDTH-1:0]           cnt_in;
   logic [DATA_WIDTH-1:0]          q;
   logic                           q_valid;
   logic                           locked;
   logic                           phase_inv;
   logic                           state_dbg;

   modport master (
      output en, signal_in, sin_in, cnt_in,
      input  q, q_valid, locked, phase_inv, state_dbg
   );

   modport slave (
      input  en, signal_in, sin_in, cnt_in,
      output q, q_valid, locked, phase_inv, state_dbg
   );
endinterface

// File: rtl/bpsk_correlator_rx.sv
// BPSK integrate-and-dump receiver: correlates samples against the local sine,
// slices one bit per symbol, hunts for the sync word and assembles codewords.
module bpsk_correlator_rx #(
   parameter int                    SAMPLE_NUMBER = 256,
   parameter int                    SAMPLE_WIDTH  = 12,
   parameter int                    DATA_WIDTH    = 12,
   parameter int                    SYNC_WIDTH    = 8,
   parameter logic [SYNC_WIDTH-1:0] SYNC_WORD     = 8'hA5
) (
   input logic                 clk,
   input logic                 arstn,
   bpsk_correlator_rx_if.slave bus
);
   localparam int CNT_W  = $clog2(SAMPLE_NUMBER);
   localparam int PROD_W = 2 * SAMPLE_WIDTH;
   localparam int ACC_W  = PROD_W + CNT_W;
   localparam int BIT_W  = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_NUMBER - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic                    armed_q, armed_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [SYNC_WIDTH-1:0]   sync_q, sync_d;
   logic [DATA_WIDTH-1:0]   cw_q, cw_d;
   logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]   q_q, q_d;
   logic                    q_valid_q, q_valid_d;
   logic                    phase_inv_q, phase_inv_d;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  sum;
   logic                     cnt_zero;
   logic                     armed_eff;
   logic                     decide;
   logic                     rx_bit;
   logic                     data_bit;
   logic [SYNC_WIDTH-1:0]    sync_shift;
   logic [DATA_WIDTH-1:0]    cw_shift;

   assign prod      = $signed(bus.signal_in) * $signed(bus.sin_in);
   assign prod_ext  = {{CNT_W{prod[PROD_W-1]}}, prod};
   assign sum       = acc_q + prod_ext;
   assign cnt_zero  = (bus.cnt_in == '0);
   // The cnt_in==0 cycle that arms the receiver already belongs to a full symbol.
   assign armed_eff = armed_q || cnt_zero;
   assign decide    = bus.en && armed_eff && (bus.cnt_in == LAST_CNT);
   // Strictly positive correlation slices to 1; a zero tie slices to 0.
   assign rx_bit    = !sum[ACC_W-1] && (sum != '0);

   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      acc_d       = acc_q;
      sync_d      = sync_q;
      cw_d        = cw_q;
      bit_cnt_d   = bit_cnt_q;
      q_d         = q_q;
      q_valid_d   = 1'b0;
      phase_inv_d = phase_inv_q;
      sync_shift  = {sync_q[SYNC_WIDTH-2:0], rx_bit};
      data_bit    = rx_bit ^ phase_inv_q;
      cw_shift    = {cw_q[DATA_WIDTH-2:0], data_bit};

      if (bus.en) begin
         if (cnt_zero) armed_d = 1'b1;
         if (armed_eff) acc_d = cnt_zero ? prod_ext : sum;
         if (decide) begin
            case (state_q)
               HUNT: begin
                  sync_d = sync_shift;
                  if (sync_shift == SYNC_WORD) begin
                     state_d     = DATA;
                     phase_inv_d = 1'b0;
                     bit_cnt_d   = '0;
                  end else if (sync_shift == ~SYNC_WORD) begin
                     state_d     = DATA;
                     phase_inv_d = 1'b1;
                     bit_cnt_d   = '0;
                  end
               end
               DATA: begin
                  cw_d      = cw_shift;
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  if (bit_cnt_q == LAST_BIT) begin
                     q_d       = cw_shift;
                     q_valid_d = 1'b1;
                     sync_d    = '0;
                     bit_cnt_d = '0;
                     state_d   = HUNT;
                  end
               end
               default: state_d = HUNT;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q     <= HUNT;
         armed_q     <= 1'b0;
         acc_q       <= '0;
         sync_q      <= '0;
         cw_q        <= '0;
         bit_cnt_q   <= '0;
         q_q         <= '0;
         q_valid_q   <= 1'b0;
         phase_inv_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         acc_q       <= acc_d;
         sync_q      <= sync_d;
         cw_q        <= cw_d;
         bit_cnt_q   <= bit_cnt_d;
         q_q         <= q_d;
         q_valid_q   <= q_valid_d;
         phase_inv_q <= phase_inv_d;
      end
   end

   assign bus.q         = q_q;
   assign bus.q_valid   = q_valid_q;
   assign bus.locked    = (state_q == DATA);
   assign bus.phase_inv = phase_inv_q;
   assign bus.state_dbg = state_q;
endmodule
